// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that adds two WIDTH-bit operands DIGIT
// bits per clock, least-significant digit first, with a registered carry
// between digits. start/ready/done handshake; reports carry-out and signed
// overflow. Defining SERIAL_ADDER_SUB_EN adds a `sub` port for a - b.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Reject parameter sets that cannot be split into whole digits.
  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;      // A, shifted right one digit per RUN cycle
  logic [WIDTH-1:0] op_b;      // B', shifted the same way
  logic [WIDTH-1:0] acc;       // result digits shifted in from the top
  logic             carry;     // carry into the current digit
  logic [CNT_W-1:0] cnt;
  logic             a_msb;     // sign bits of A and B' kept for overflow
  logic             b_msb;

  logic [WIDTH-1:0] b_eff;
  logic             carry_init;
  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] acc_next;

  // Operand conditioning at capture time: B' and the initial carry.
  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    b_eff      = b;
    carry_init = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_eff      = ~b;
      carry_init = 1'b1;
    end
`endif
  end

  // One digit of addition, and the result register with that digit
  // inserted at the top (earlier digits move down toward bit 0).
  always_comb begin
    digit_sum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
              + (DIGIT + 1)'(carry);
    acc_next  = (acc >> DIGIT)
              | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // Control FSM and datapath registers; all outputs are registered.
  // NOTE: sequential state uses non-blocking (<=) so every register sees
  // the pre-edge values of the others, matching real flip-flop behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b_eff;
            carry <= carry_init;
            acc   <= '0;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          acc   <= acc_next;
          carry <= digit_sum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum      <= acc_next;
            cout     <= digit_sum[DIGIT];
            overflow <= (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
            done     <= 1'b1;
            ready    <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=16, DIGIT=4, so N=4).
// Build with +define+SERIAL_ADDER_SUB_EN to also exercise subtraction.
module tb_serial_adder;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Last completed result as known to the bench (held during RUN).
  logic [WIDTH-1:0] last_sum  = '0;
  logic             last_cout = 1'b0;
  logic             last_ovf  = 1'b0;

  serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .ready    (ready),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation from an accepted start. If inject > 0, a start with
  // other operands is pulsed during RUN cycle `inject` and must be ignored.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic tc, input logic [15:0] es, input logic ec,
                        input logic eo, input int inject);
    a = ta; b = tbv; cin = tc; start = 1'b1;
    tick();                                   // accepting edge k
    start = 1'b0;
    check({tag, " ready low after accept"}, ready, 0);
    check({tag, " sum held at accept"}, sum, last_sum);
    for (int i = 1; i < N; i++) begin
      if (i == inject) begin
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      end
      tick();
      start = 1'b0;
      check({tag, " ready low in RUN"}, ready, 0);
      check({tag, " no done in RUN"}, done, 0);
      check({tag, " sum held in RUN"}, sum, last_sum);
      check({tag, " cout held in RUN"}, cout, last_cout);
    end
    tick();                                   // edge k+N
    check({tag, " done"}, done, 1);
    check({tag, " ready at done"}, ready, 1);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
    check({tag, " overflow"}, overflow, eo);
    last_sum = es; last_cout = ec; last_ovf = eo;
    tick();
    check({tag, " done one cycle"}, done, 0);
    check({tag, " sum held after"}, sum, es);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #12;
    check("reset ready", ready, 1);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Basic add: latency N, ready low, one done pulse.
    run_op("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    // Wrap with carry out.
    run_op("addFFFF", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    // Carry-in drives signed overflow.
    run_op("add7FFF", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 0);
    // Start pulsed during RUN with different operands is ignored.
    run_op("ignore", 16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0, 2);
    for (int i = 0; i < N + 1; i++) begin
      tick();
      check("ignore no extra done", done, 0);
      check("ignore stays idle", ready, 1);
    end

    // Reset after two digits of 0x00FF + 0x0001: immediate, no done.
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre-reset busy", ready, 0);
    reset = 1'b1;
    #1;                                       // no clock edge in between
    check("async reset ready", ready, 1);
    check("async reset sum", sum, 0);
    check("async reset cout", cout, 0);
    check("async reset overflow", overflow, 0);
    check("async reset done", done, 0);
    last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
    #1;
    reset = 1'b0;
    for (int i = 0; i < N + 1; i++) begin
      tick();
      check("aborted op no done", done, 0);
    end
    run_op("after reset", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 0);

    // start held high: one operation every N+1 cycles.
    begin
      logic [15:0] opa [3];
      logic [15:0] exs [3];
      logic        exc [3];
      logic        exo [3];
      opa = '{16'h0001, 16'h0002, 16'h8000};
      exs = '{16'h0002, 16'h0004, 16'h0000};
      exc = '{1'b0, 1'b0, 1'b1};
      exo = '{1'b0, 1'b0, 1'b1};
      a = opa[0]; b = opa[0]; cin = 1'b0; start = 1'b1;
      for (int op = 0; op < 3; op++) begin
        tick();                               // accepting edge
        check("stream accept", ready, 0);
        check("stream no done at accept", done, 0);
        for (int i = 1; i < N; i++) begin
          tick();
          check("stream no done in RUN", done, 0);
        end
        tick();
        check("stream done", done, 1);
        check("stream sum", sum, exs[op]);
        check("stream cout", cout, exc[op]);
        check("stream overflow", overflow, exo[op]);
        if (op < 2) begin
          a = opa[op + 1]; b = opa[op + 1];
        end else begin
          start = 1'b0;
        end
      end
      last_sum = 16'h0000; last_cout = 1'b1; last_ovf = 1'b1;
      tick();
      check("stream ends", done, 0);
      check("stream idle", ready, 1);
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: cin ignored, initial carry forced to 1.
    sub = 1'b1;
    run_op("sub 5-7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("sub 8000-1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
    sub = 1'b0;
    run_op("add after sub", 16'h1000, 16'h0234, 1'b1, 16'h1235, 1'b0, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
